// File: rtl/dcache_load_port_arbiter.sv
// Shares one dcache load port between the CPU load unit and the prefetcher (CPU has priority).
// Latency: index request and gnt pass through combinationally; tag phase follows one cycle after gnt.
// Backpressure: the selected requester is locked until gnt; new grants stop when the owner FIFO is full.

package dcache_load_port_arbiter_pkg;

  // Request bundle towards a dcache read port
  typedef struct packed {
    logic [11:0] address_index;
    logic [19:0] address_tag;
    logic [31:0] data_wdata;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [1:0]  data_size;
    logic        kill_req;
    logic        tag_valid;
  } dcache_req_i_t;

  // Response bundle from a dcache read port
  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
  } dcache_req_o_t;

endpackage

module dcache_load_port_arbiter
  import dcache_load_port_arbiter_pkg::*;
#(
  parameter int MaxOutst   = 4,
  parameter int PfMaxOutst = 2
) (
  input  logic                         clk,
  input  logic                         rst_ni,
  input  dcache_req_i_t                cpu_port_i,
  output dcache_req_o_t                cpu_port_o,
  input  dcache_req_i_t                pf_port_i,
  output dcache_req_o_t                pf_port_o,
  output dcache_req_i_t                cache_port_o,
  input  dcache_req_o_t                cache_port_i,
  output logic [$clog2(MaxOutst+1)-1:0] outst_cnt_o,
  output logic [31:0]                  pf_issued_o,
  output logic                         err_o
);

  localparam int CntW = $clog2(MaxOutst + 1);
  localparam int PtrW = $clog2(MaxOutst);
  localparam logic [CntW-1:0] MaxCnt   = CntW'(MaxOutst);
  localparam logic [CntW-1:0] PfMaxCnt = CntW'(PfMaxOutst);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(MaxOutst - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCK_CPU = 2'd1,
    LOCK_PF  = 2'd2
  } state_e;

  state_e          r_state;
  logic [MaxOutst-1:0] r_own;        // owner bit per FIFO slot: 0=CPU, 1=PF
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] r_pf_outst;
  logic            r_tag_pend;
  logic            r_tag_owner;
  logic [31:0]     r_pf_issued;
  logic            r_err;

  logic            w_full;
  logic            w_pf_ok;
  logic            w_sel_vld;
  logic            w_sel_pf;
  dcache_req_i_t   w_sel;
  dcache_req_i_t   w_tag;
  logic            w_req;
  logic            w_gnt;
  logic            w_pop;
  logic            w_head_pf;
  logic            w_pf_push;
  logic            w_pf_pop;

  // Full and prefetch-throttle decisions use registered counts only, so
  // a same-cycle rvalid never opens a slot for a same-cycle grant.
  assign w_full  = (r_cnt == MaxCnt);
  assign w_pf_ok = (r_pf_outst < PfMaxCnt);

  // Pick the index-phase owner: locked requester wins, else CPU over prefetch
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_pf  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_full && cpu_port_i.data_req) begin
          w_sel_vld = 1'b1;
        end else if (!w_full && pf_port_i.data_req && w_pf_ok) begin
          w_sel_vld = 1'b1;
          w_sel_pf  = 1'b1;
        end
      end
      LOCK_CPU: begin
        w_sel_vld = 1'b1;
      end
      LOCK_PF: begin
        w_sel_vld = 1'b1;
        w_sel_pf  = 1'b1;
      end
      default: begin
        w_sel_vld = 1'b0;
      end
    endcase
  end

  assign w_sel     = w_sel_pf    ? pf_port_i : cpu_port_i;
  assign w_tag     = r_tag_owner ? pf_port_i : cpu_port_i;
  assign w_req     = w_sel_vld && w_sel.data_req;
  assign w_gnt     = w_req && cache_port_i.data_gnt;
  assign w_pop     = cache_port_i.data_rvalid && (r_cnt != '0);
  assign w_head_pf = r_own[r_rd_ptr];
  assign w_pf_push = w_gnt && w_sel_pf;
  assign w_pf_pop  = w_pop && w_head_pf;

  // Drive the cache port: index fields from the index owner, tag fields from the tag owner
  always_comb begin
    cache_port_o = '0;
    if (w_sel_vld) begin
      cache_port_o.data_req      = w_req;
      cache_port_o.address_index = w_sel.address_index;
      cache_port_o.data_wdata    = w_sel.data_wdata;
      cache_port_o.data_we       = w_sel.data_we;
      cache_port_o.data_be       = w_sel.data_be;
      cache_port_o.data_size     = w_sel.data_size;
    end
    if (r_tag_pend) begin
      cache_port_o.address_tag = w_tag.address_tag;
      cache_port_o.tag_valid   = w_tag.tag_valid;
      cache_port_o.kill_req    = w_tag.kill_req;
    end
  end

  // Route gnt to the selected requester and rvalid to the FIFO head owner; rdata is shared
  always_comb begin
    cpu_port_o             = '0;
    pf_port_o              = '0;
    cpu_port_o.data_gnt    = w_gnt && !w_sel_pf;
    pf_port_o.data_gnt     = w_gnt && w_sel_pf;
    cpu_port_o.data_rvalid = w_pop && !w_head_pf;
    pf_port_o.data_rvalid  = w_pop && w_head_pf;
    cpu_port_o.data_rdata  = cache_port_i.data_rdata;
    pf_port_o.data_rdata   = cache_port_i.data_rdata;
  end

  // Index-phase FSM: lock onto a requester that asked but was not granted
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !w_gnt) begin
            r_state <= w_sel_pf ? LOCK_PF : LOCK_CPU;
          end
        end
        LOCK_CPU, LOCK_PF: begin
          // Either granted, or the requester withdrew: both release the lock
          if (w_gnt || !w_req) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Owner FIFO: push the issuer on gnt, pop on rvalid; wrap explicitly for any depth
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_own    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_gnt) begin
        r_own[r_wr_ptr] <= w_sel_pf;
        r_wr_ptr        <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + PtrW'(1);
      end
      case ({w_gnt, w_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Prefetch-owned entries in flight, used to throttle the prefetcher
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_pf_outst <= '0;
    end else begin
      case ({w_pf_push, w_pf_pop})
        2'b10:   r_pf_outst <= r_pf_outst + CntW'(1);
        2'b01:   r_pf_outst <= r_pf_outst - CntW'(1);
        default: r_pf_outst <= r_pf_outst;
      endcase
    end
  end

  // Remember who owns the tag phase in the cycle after each gnt
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_tag_pend  <= 1'b0;
      r_tag_owner <= 1'b0;
    end else begin
      r_tag_pend <= w_gnt;
      if (w_gnt) begin
        r_tag_owner <= w_sel_pf;
      end
    end
  end

  // Saturating prefetch grant counter and sticky orphan-rvalid flag
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_pf_issued <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_pf_push && (r_pf_issued != 32'hFFFF_FFFF)) begin
        r_pf_issued <= r_pf_issued + 32'd1;
      end
      if (cache_port_i.data_rvalid && (r_cnt == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign outst_cnt_o = r_cnt;
  assign pf_issued_o = r_pf_issued;
  assign err_o       = r_err;

endmodule

// File: tb/tb_dcache_load_port_arbiter.sv
// Directed bench for dcache_load_port_arbiter with a small dcache model and an owner/rdata scoreboard.
// Inputs change 1 time unit after posedge; combinational outputs are sampled on the negedge.
// The dcache model returns rvalid two cycles after each expected grant unless responses are disabled.

module tb_dcache_load_port_arbiter;
  import dcache_load_port_arbiter_pkg::*;

  localparam logic [11:0] CPU_IDX = 12'h1A4;
  localparam logic [11:0] PF_IDX  = 12'h2B8;
  localparam logic [19:0] CPU_TAG = 20'hC0DE5;
  localparam logic [19:0] PF_TAG  = 20'hF00D7;

  typedef struct packed {
    logic        pf;
    logic [31:0] d;
  } sb_t;

  logic          clk;
  logic          rst_n;
  dcache_req_i_t cpu_i;
  dcache_req_i_t pf_i;
  dcache_req_i_t cache_o;
  dcache_req_o_t cpu_o;
  dcache_req_o_t pf_o;
  dcache_req_o_t cache_i;
  logic [2:0]    outst;
  logic [31:0]   pf_issued;
  logic          err;

  int          n_vec;
  int          n_err;
  int          exp_sel;      // 0 none, 1 CPU, 2 PF expected on the index phase
  int          prev_gnt;     // expected owner of the current tag phase
  bit          auto_resp;
  bit          rv_v [3];
  logic [31:0] rv_d [3];
  int          resp_seq;
  int          max_outst;
  int          exp_pf_issued;
  sb_t         sb_q[$];

  dcache_load_port_arbiter #(.MaxOutst(4), .PfMaxOutst(2)) dut (
    .clk          (clk),
    .rst_ni       (rst_n),
    .cpu_port_i   (cpu_i),
    .cpu_port_o   (cpu_o),
    .pf_port_i    (pf_i),
    .pf_port_o    (pf_o),
    .cache_port_o (cache_o),
    .cache_port_i (cache_i),
    .outst_cnt_o  (outst),
    .pf_issued_o  (pf_issued),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Negedge checks: gnt routing, index/tag muxing, rvalid routing via scoreboard
  task automatic observe();
    logic e_cg;
    logic e_pg;
    sb_t  e;
    e_cg = (exp_sel == 1) && cache_i.data_gnt;
    e_pg = (exp_sel == 2) && cache_i.data_gnt;
    chk("cpu_gnt", 64'(cpu_o.data_gnt), 64'(e_cg));
    chk("pf_gnt", 64'(pf_o.data_gnt), 64'(e_pg));
    chk("cache_req", 64'(cache_o.data_req), 64'(exp_sel != 0));
    if (exp_sel != 0)
      chk("index", 64'(cache_o.address_index), 64'((exp_sel == 1) ? CPU_IDX : PF_IDX));
    chk("tag_valid", 64'(cache_o.tag_valid), 64'(prev_gnt != 0));
    if (prev_gnt == 1) begin
      chk("tag_cpu", 64'(cache_o.address_tag), 64'(CPU_TAG));
      chk("kill_cpu", 64'(cache_o.kill_req), 64'(cpu_i.kill_req));
    end else if (prev_gnt == 2) begin
      chk("tag_pf", 64'(cache_o.address_tag), 64'(PF_TAG));
      chk("kill_pf", 64'(cache_o.kill_req), 64'(pf_i.kill_req));
    end else begin
      chk("kill_idle", 64'(cache_o.kill_req), 64'd0);
    end
    if (cache_i.data_rvalid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("cpu_rvalid", 64'(cpu_o.data_rvalid), 64'(!e.pf));
      chk("pf_rvalid", 64'(pf_o.data_rvalid), 64'(e.pf));
      chk(e.pf ? "pf_rdata" : "cpu_rdata", 64'(e.pf ? pf_o.data_rdata : cpu_o.data_rdata), 64'(e.d));
    end else begin
      chk("no_rvalid", 64'({cpu_o.data_rvalid, pf_o.data_rvalid}), 64'd0);
    end
    if (int'(outst) > max_outst) max_outst = int'(outst);
    if (e_cg || e_pg) begin
      resp_seq++;
      e.pf = e_pg;
      e.d  = 32'hA500_0000 + 32'(resp_seq);
      sb_q.push_back(e);
      if (auto_resp) begin
        rv_v[2] = 1'b1;
        rv_d[2] = e.d;
      end
      if (e_pg) exp_pf_issued++;
    end
    prev_gnt = e_cg ? 1 : (e_pg ? 2 : 0);
  endtask

  // Advance the dcache response pipeline just after the clock edge
  task automatic advance();
    rv_v[0] = rv_v[1];  rv_d[0] = rv_d[1];
    rv_v[1] = rv_v[2];  rv_d[1] = rv_d[2];
    rv_v[2] = 1'b0;     rv_d[2] = '0;
    cache_i.data_rvalid = rv_v[0];
    cache_i.data_rdata  = rv_v[0] ? rv_d[0] : 32'h0;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    advance();
  endtask

  task automatic step(input bit c, input bit p, input bit g, input int e);
    cpu_i.data_req   = c;
    pf_i.data_req    = p;
    cache_i.data_gnt = g;
    exp_sel          = e;
    tick();
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    cpu_i.data_req   = 1'b0;
    pf_i.data_req    = 1'b0;
    cpu_i.kill_req   = 1'b0;
    pf_i.kill_req    = 1'b0;
    cache_i          = '0;
    for (int i = 0; i < 3; i++) begin
      rv_v[i] = 1'b0;
      rv_d[i] = '0;
    end
    sb_q.delete();
    prev_gnt      = 0;
    exp_sel       = 0;
    exp_pf_issued = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; resp_seq = 0; max_outst = 0; auto_resp = 1'b1;
    cpu_i = '0;
    cpu_i.address_index = CPU_IDX; cpu_i.address_tag = CPU_TAG; cpu_i.tag_valid = 1'b1;
    cpu_i.data_be = 4'hF; cpu_i.data_size = 2'd2;
    pf_i = '0;
    pf_i.address_index = PF_IDX; pf_i.address_tag = PF_TAG; pf_i.tag_valid = 1'b1;
    pf_i.data_be = 4'hF; pf_i.data_size = 2'd3;
    rst_n = 1'b0;
    cache_i = '0;
    @(posedge clk);
    do_reset();

    // Reset state
    chk("rst_outst", 64'(outst), 64'd0);
    chk("rst_pf_issued", 64'(pf_issued), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    step(0, 0, 1, 0);

    // CPU-only: 8 back-to-back grants, rvalid two cycles later
    max_outst = 0;
    for (int i = 0; i < 8; i++) step(1, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    chk("t1_max_outst", 64'(max_outst), 64'd2);
    chk("t1_outst_drained", 64'(outst), 64'd0);
    chk("t1_err", 64'(err), 64'd0);

    // Contention: CPU first, prefetch next cycle, responses in that order
    step(1, 1, 1, 1);
    step(0, 1, 1, 2);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

    // Lock: prefetch held 3 cycles without gnt while CPU also asks
    step(0, 1, 0, 2);
    step(1, 1, 0, 2);
    step(1, 1, 0, 2);
    step(1, 1, 1, 2);
    step(1, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

    // Kill: CPU tag phase killed; CPU kill during PF tag phase is ignored
    step(1, 0, 1, 1);
    cpu_i.kill_req = 1'b1;
    step(0, 1, 1, 2);
    step(0, 0, 1, 0);
    cpu_i.kill_req = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    chk("t5_outst_drained", 64'(outst), 64'd0);
    chk("t5_err", 64'(err), 64'd0);

    // Throttle and full with no responses
    auto_resp = 1'b0;
    step(0, 1, 1, 2);
    step(0, 1, 1, 2);
    step(0, 1, 1, 0);
    chk("t4_outst_pf", 64'(outst), 64'd2);
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    step(1, 1, 1, 0);
    chk("t4_outst_full", 64'(outst), 64'd4);
    step(0, 1, 1, 0);
    chk("t4_pf_issued", 64'(pf_issued), 64'(exp_pf_issued));

    // Reset with 4 outstanding drops all tracking
    do_reset();
    chk("t6_outst", 64'(outst), 64'd0);
    chk("t6_pf_issued", 64'(pf_issued), 64'd0);
    chk("t6_err", 64'(err), 64'd0);
    auto_resp = 1'b1;
    step(0, 1, 1, 2);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    chk("t6_pf_issued_after", 64'(pf_issued), 64'(exp_pf_issued));
    chk("t6_outst_after", 64'(outst), 64'd0);

    // Orphan rvalid with empty FIFO: dropped and flagged, flag is sticky
    cache_i.data_rvalid = 1'b1;
    cache_i.data_rdata  = 32'hDEAD_BEEF;
    exp_sel = 0;
    tick();
    chk("err_set", 64'(err), 64'd1);
    step(0, 0, 1, 0);
    chk("err_sticky", 64'(err), 64'd1);
    chk("err_outst", 64'(outst), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
